wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 41 ++++
 rtl/wb_stage.sv | 138 +++++++++++++
 tb/tb_wb_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : Write-back stage bus bundle: ALU result, load result and
//                register-file write port, plus stall/error status.
//  Revision    : 1.0
// ============================================================================
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            alu_valid_i;
    logic [4:0]      alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            alu_stall_o;

    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [4:0]      lsu_rd_i;
    logic [XLEN-1:0] lsu_data_i;
    logic [2:0]      lsu_funct3_i;

    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            err_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_funct3_i,
        output alu_stall_o, lsu_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, err_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_funct3_i,
        input  alu_stall_o, lsu_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Write-back arbiter: ALU results win, loads buffered in a
//                2-entry FIFO; a starve counter stalls the ALU so loads drain.
//                Optional load sign/zero extension under macro WB_LOAD_EXT_EN.
//  Revision    : 1.0
// ============================================================================
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int STARVE_LIM = 4
) (
    input  wire logic   clk,
    input  wire logic   rstn_i,
    wb_stage_if.slave   bus
);
    localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_LIM);
    localparam logic [3:0] c_STARVE_MAX = 4'd15;

    logic [4:0]      r_fifo_rd   [2];
    logic [XLEN-1:0] r_fifo_data [2];
`ifdef WB_LOAD_EXT_EN
    logic [2:0]      r_fifo_f3   [2];
`endif
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic [3:0]      r_starve;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_err;

    logic            w_ready;
    logic            w_stall;
    logic            w_push;
    logic            w_alu_req;
    logic            w_alu_win;
    logic            w_empty;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;

    assign w_ready   = (r_count < 2'd2);
    assign w_stall   = (r_starve >= c_STARVE_LIM);
    assign w_push    = bus.lsu_valid_i && w_ready;
    assign w_alu_req = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
    assign w_alu_win = w_alu_req && !w_stall;
    assign w_empty   = (r_count == 2'd0);
    assign w_pop     = !w_empty && !w_alu_win;
    assign w_head_rd = r_fifo_rd[r_rd_ptr];

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        w_head_data = r_fifo_data[r_rd_ptr];
        case (r_fifo_f3[r_rd_ptr])
            3'b000:  w_head_data = {{(XLEN-8){r_fifo_data[r_rd_ptr][7]}},   r_fifo_data[r_rd_ptr][7:0]};
            3'b001:  w_head_data = {{(XLEN-16){r_fifo_data[r_rd_ptr][15]}}, r_fifo_data[r_rd_ptr][15:0]};
            3'b100:  w_head_data = {{(XLEN-8){1'b0}},  r_fifo_data[r_rd_ptr][7:0]};
            3'b101:  w_head_data = {{(XLEN-16){1'b0}}, r_fifo_data[r_rd_ptr][15:0]};
            default: w_head_data = r_fifo_data[r_rd_ptr];
        endcase
    end
`else
    // Load type is irrelevant when extension is disabled.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^bus.lsu_funct3_i;
    assign w_head_data     = r_fifo_data[r_rd_ptr];
`endif

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_rd[i]   <= '0;
                r_fifo_data[i] <= '0;
`ifdef WB_LOAD_EXT_EN
                r_fifo_f3[i]   <= '0;
`endif
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= 4'd0;
            r_we     <= 1'b0;
            r_waddr  <= 5'd0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wr_ptr]   <= bus.lsu_rd_i;
                r_fifo_data[r_wr_ptr] <= bus.lsu_data_i;
`ifdef WB_LOAD_EXT_EN
                r_fifo_f3[r_wr_ptr]   <= bus.lsu_funct3_i;
`endif
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            // Counts only cycles where a buffered load lost to the ALU.
            if (w_empty || w_pop) begin
                r_starve <= 4'd0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end

            if (w_alu_req && w_stall) begin
                r_err <= 1'b1;
            end

            if (w_alu_win) begin
                r_we    <= 1'b1;
                r_waddr <= bus.alu_rd_i;
                r_wdata <= bus.alu_data_i;
            end else if (w_pop) begin
                r_we    <= (w_head_rd != 5'd0);
                r_waddr <= w_head_rd;
                r_wdata <= w_head_data;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    assign bus.alu_stall_o = w_stall;
    assign bus.lsu_ready_o = w_ready;
    assign bus.rf_we_o     = r_we;
    assign bus.rf_waddr_o  = r_waddr;
    assign bus.rf_wdata_o  = r_wdata;
    assign bus.err_o       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Directed bench for wb_stage with a queue-based reference model.
//  Revision    : 1.0
// ============================================================================
module tb_wb_stage;
    localparam int XLEN = 32;
    localparam int LIM  = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    wb_stage_if #(.XLEN(XLEN)) bus ();

    wb_stage #(.XLEN(XLEN), .STARVE_LIM(LIM)) dut (
        .clk    (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  f3;
    } ent_t;

    ent_t        q[$];
    int          m_starve = 0;
    bit          m_err    = 1'b0;
    bit          m_we     = 1'b0;
    logic [4:0]  m_addr   = '0;
    logic [31:0] m_data   = '0;

    function automatic logic [31:0] ext_load(input logic [31:0] d, input logic [2:0] f3);
`ifdef WB_LOAD_EXT_EN
        case (f3)
            3'b000:  return 32'($signed(d[7:0]));
            3'b001:  return 32'($signed(d[15:0]));
            3'b100:  return 32'(d[7:0]);
            3'b101:  return 32'(d[15:0]);
            default: return d;
        endcase
`else
        return d + 32'(f3) * 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration and FIFO behaviour stated as queue operations.
    initial begin
        bit stl, rdy, req, win, pp;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                q.delete();
                m_starve = 0; m_err = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
            end else begin
                stl = (m_starve >= LIM);
                rdy = (q.size() < 2);
                req = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
                win = req && !stl;
                pp  = (q.size() > 0) && !win;
                if (req && stl) m_err = 1'b1;
                m_we = 1'b0;
                if (win) begin
                    m_we = 1'b1; m_addr = bus.alu_rd_i; m_data = bus.alu_data_i;
                end else if (pp) begin
                    m_we = (q[0].rd != 5'd0); m_addr = q[0].rd; m_data = ext_load(q[0].data, q[0].f3);
                end
                if (q.size() == 0 || pp) m_starve = 0;
                else if (m_starve < 15) m_starve = m_starve + 1;
                if (pp) void'(q.pop_front());
                if (bus.lsu_valid_i && rdy)
                    q.push_back('{rd: bus.lsu_rd_i, data: bus.lsu_data_i, f3: bus.lsu_funct3_i});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_we",    32'(bus.rf_we_o),     32'(m_we));
            chk("m_waddr", 32'(bus.rf_waddr_o),  32'(m_addr));
            chk("m_wdata", bus.rf_wdata_o,       m_data);
            chk("m_ready", 32'(bus.lsu_ready_o), 32'(q.size() < 2));
            chk("m_stall", 32'(bus.alu_stall_o), 32'(m_starve >= LIM));
            chk("m_err",   32'(bus.err_o),       32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] order[$];
        bit seen_stall;
        bit prev_stall;
        bit clr_checked;
        bit found;

        bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
        bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0; bus.lsu_funct3_i = 3'b010;
        repeat (3) cyc();
        chk("rst_we",    32'(bus.rf_we_o), 32'd0);
        chk("rst_waddr", 32'(bus.rf_waddr_o), 32'd0);
        chk("rst_wdata", bus.rf_wdata_o, 32'd0);
        chk("rst_ready", 32'(bus.lsu_ready_o), 32'd1);
        chk("rst_stall", 32'(bus.alu_stall_o), 32'd0);
        chk("rst_err",   32'(bus.err_o), 32'd0);
        rstn = 1'b1;
        cyc();

        // ALU write, one-cycle latency
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'h1234;
        cyc();
        bus.alu_valid_i = 1'b0;
        chk("alu_we",    32'(bus.rf_we_o), 32'd1);
        chk("alu_waddr", 32'(bus.rf_waddr_o), 32'd5);
        chk("alu_wdata", bus.rf_wdata_o, 32'h1234);
        cyc();
        chk("alu_we_once", 32'(bus.rf_we_o), 32'd0);

        // Load write, two-cycle latency
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd3; bus.lsu_data_i = 32'hDEAD_BEEF; bus.lsu_funct3_i = 3'b010;
        cyc();
        bus.lsu_valid_i = 1'b0;
        chk("ld_we_n1", 32'(bus.rf_we_o), 32'd0);
        cyc();
        chk("ld_we",    32'(bus.rf_we_o), 32'd1);
        chk("ld_waddr", 32'(bus.rf_waddr_o), 32'd3);
        chk("ld_wdata", bus.rf_wdata_o, 32'hDEAD_BEEF);
        cyc();

        // Loads starved by a busy ALU; upstream honours the stall
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd1; bus.alu_data_i = 32'd100;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd10; bus.lsu_data_i = 32'hAAAA;
        cyc();
        bus.lsu_rd_i = 5'd11; bus.lsu_data_i = 32'hBBBB; bus.alu_data_i = 32'd101;
        cyc();
        bus.lsu_valid_i = 1'b0;
        chk("full_ready", 32'(bus.lsu_ready_o), 32'd0);
        seen_stall = 1'b0; prev_stall = 1'b0; clr_checked = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.rf_we_o && (bus.rf_waddr_o == 5'd10 || bus.rf_waddr_o == 5'd11))
                order.push_back(bus.rf_waddr_o);
            if (prev_stall && !clr_checked) begin
                chk("stall_clear", 32'(bus.alu_stall_o), 32'd0);
                clr_checked = 1'b1;
            end
            if (bus.alu_stall_o) seen_stall = 1'b1;
            prev_stall = bus.alu_stall_o;
            bus.alu_valid_i = !bus.alu_stall_o;
            bus.alu_data_i  = 32'(200 + i);
            cyc();
        end
        bus.alu_valid_i = 1'b0;
        chk("stall_seen", 32'(seen_stall), 32'd1);
        chk("drain_cnt",  32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("drain_1st", 32'(order[0]), 32'd10);
            chk("drain_2nd", 32'(order[1]), 32'd11);
        end
        chk("no_err", 32'(bus.err_o), 32'd0);
        cyc();

        // rd=0 from both sources
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'h55;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd0; bus.lsu_data_i = 32'h66;
        cyc();
        bus.alu_valid_i = 1'b0; bus.lsu_valid_i = 1'b0;
        chk("x0_we_a", 32'(bus.rf_we_o), 32'd0);
        cyc();
        chk("x0_we_l", 32'(bus.rf_we_o), 32'd0);
        cyc();
        chk("x0_ready", 32'(bus.lsu_ready_o), 32'd1);

        // Load extension
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd9; bus.lsu_data_i = 32'h80; bus.lsu_funct3_i = 3'b000;
        cyc();
        bus.lsu_funct3_i = 3'b100;
        cyc();
        bus.lsu_funct3_i = 3'b001; bus.lsu_data_i = 32'h8000;
`ifdef WB_LOAD_EXT_EN
        chk("ext_lb", bus.rf_wdata_o, 32'hFFFF_FF80);
`else
        chk("ext_lb", bus.rf_wdata_o, 32'h0000_0080);
`endif
        cyc();
        bus.lsu_valid_i = 1'b0; bus.lsu_funct3_i = 3'b010;
        chk("ext_lbu", bus.rf_wdata_o, 32'h0000_0080);
        cyc();
`ifdef WB_LOAD_EXT_EN
        chk("ext_lh", bus.rf_wdata_o, 32'hFFFF_8000);
`else
        chk("ext_lh", bus.rf_wdata_o, 32'h0000_8000);
`endif
        cyc();

        // Protocol violation: ALU keeps driving through the stall
        bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd7; bus.alu_data_i = 32'h77;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd4; bus.lsu_data_i = 32'h44;
        cyc();
        bus.lsu_valid_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.alu_stall_o) found = 1'b1;
            else cyc();
        end
        chk("viol_stall_reached", 32'(found), 32'd1);
        cyc();
        bus.alu_valid_i = 1'b0;
        chk("viol_err",   32'(bus.err_o), 32'd1);
        chk("viol_waddr", 32'(bus.rf_waddr_o), 32'd4);
        chk("viol_wdata", bus.rf_wdata_o, 32'h44);
        cyc();
        chk("err_sticky", 32'(bus.err_o), 32'd1);

        // Reset with two buffered loads
        bus.alu_valid_i = 1'b1; bus.alu_data_i = 32'h78;
        bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd12; bus.lsu_data_i = 32'hC12;
        cyc();
        bus.lsu_rd_i = 5'd13; bus.lsu_data_i = 32'hC13;
        cyc();
        bus.lsu_valid_i = 1'b0; bus.alu_valid_i = 1'b0;
        chk("pre_rst_full", 32'(bus.lsu_ready_o), 32'd0);
        rstn = 1'b0;
        #2;
        chk("mid_rst_we",    32'(bus.rf_we_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.lsu_ready_o), 32'd1);
        chk("mid_rst_err",   32'(bus.err_o), 32'd0);
        cyc();
        rstn = 1'b1;
        cyc();
        chk("post_rst_we1", 32'(bus.rf_we_o), 32'd0);
        cyc();
        chk("post_rst_we2", 32'(bus.rf_we_o), 32'd0);
        chk("post_rst_ready", 32'(bus.lsu_ready_o), 32'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
